uart_tx_arbiter: RTL and testbench

- Shares one wb_uart_tx transmitter between NREQ independent byte-stream message sources, e.g. several hello-world style message generators.
- Grants the UART round-robin, one whole message at a time, terminated by i_last.
- Inserts a fixed idle gap between messages.
- Aborts a message whose owner stalls too long.
- Sits between the message generators and the UART's i_wr/i_data/o_busy handshake.

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter between NREQ
// message sources; whole messages are granted, separated by an idle gap.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int STALL_LIMIT = 1024
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NREQ-1:0]   i_req,
    input  logic [8*NREQ-1:0] i_data,
    input  logic [NREQ-1:0]   i_last,
    output logic [NREQ-1:0]   o_ack,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_uart_wr,
    output logic [7:0]        o_uart_data,
    input  logic              i_uart_busy,
    output logic              o_busy,
    output logic              o_abort
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [IW-1:0]   ptr_r, ptr_s;
    logic [NREQ-1:0] grant_r, grant_s;
    logic [SW-1:0]   stall_r, stall_s;
    logic [GW-1:0]   gap_r, gap_s;
    logic            abort_r, abort_s;
    logic [IW-1:0]   win_s;
    logic            req_own_s;
    logic            last_own_s;
    logic            accept_s;
    logic [7:0]      data_own_s;

    // First requester set after ptr, searching upward with wrap.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IW-1:0]   ptr);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // The pointer always equals the current owner while in SEND.
    assign win_s       = rr_pick(i_req, ptr_r);
    assign req_own_s   = i_req[ptr_r];
    assign last_own_s  = i_last[ptr_r];
    assign data_own_s  = i_data[{ptr_r, 3'b000} +: 8];
    assign o_uart_wr   = (state_r == ST_SEND) && req_own_s;
    assign o_uart_data = data_own_s;
    assign accept_s    = o_uart_wr && !i_uart_busy;
    assign o_ack       = accept_s ? grant_r : {NREQ{1'b0}};
    assign o_grant     = grant_r;
    assign o_busy      = (state_r != ST_IDLE);
    assign o_abort     = abort_r;

    // Next-state, grant, watchdog and gap-counter logic.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        grant_s = grant_r;
        stall_s = stall_r;
        gap_s   = gap_r;
        abort_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|i_req) begin
                    ptr_s   = win_s;
                    grant_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                    stall_s = {SW{1'b0}};
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (accept_s && last_own_s) begin
                    state_s = ST_GAP;
                    grant_s = {NREQ{1'b0}};
                    stall_s = {SW{1'b0}};
                    gap_s   = GW'(GAP_CYCLES);
                end else if (req_own_s) begin
                    stall_s = {SW{1'b0}};
                end else if (stall_r == SW'(STALL_LIMIT - 1)) begin
                    // Owner stalled too long: abort, keep ptr so it ranks last.
                    abort_s = 1'b1;
                    state_s = ST_GAP;
                    grant_s = {NREQ{1'b0}};
                    stall_s = SW'(STALL_LIMIT);
                    gap_s   = GW'(GAP_CYCLES);
                end else begin
                    stall_s = stall_r + SW'(1);
                end
            end
            ST_GAP: begin
                grant_s = {NREQ{1'b0}};
                stall_s = {SW{1'b0}};
                if (gap_r <= GW'(1)) begin
                    gap_s   = {GW{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    gap_s = gap_r - GW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = {NREQ{1'b0}};
                stall_s = {SW{1'b0}};
                gap_s   = {GW{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= IW'(NREQ - 1);
            grant_r <= {NREQ{1'b0}};
            stall_r <= {SW{1'b0}};
            gap_r   <= {GW{1'b0}};
            abort_r <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            grant_r <= grant_s;
            stall_r <= stall_s;
            gap_r   <= gap_s;
            abort_r <= abort_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter, checked every cycle
// against a message-level reference model of the arbitration rules.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int GAP   = 3;
    localparam int STALL = 8;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic [NREQ-1:0]   i_req = '0;
    logic [8*NREQ-1:0] i_data = '0;
    logic [NREQ-1:0]   i_last = '0;
    logic [NREQ-1:0]   o_ack;
    logic [NREQ-1:0]   o_grant;
    logic              o_uart_wr;
    logic [7:0]        o_uart_data;
    logic              i_uart_busy = 1'b0;
    logic              o_busy;
    logic              o_abort;

    uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .STALL_LIMIT(STALL)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data),
        .i_last(i_last), .o_ack(o_ack), .o_grant(o_grant), .o_uart_wr(o_uart_wr),
        .o_uart_data(o_uart_data), .i_uart_busy(i_uart_busy), .o_busy(o_busy),
        .o_abort(o_abort)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // requester byte queues: {last, data}
    logic [8:0] q [NREQ][$];
    int  pause [NREQ];
    int  pend_pause [NREQ];
    int  busy_mode = 0;
    logic busy_force = 1'b0;
    int  busy_cnt = 0;
    bit  rnd_mode = 1'b0;
    bit  rst_req = 1'b1;

    // reference model
    int  m_owner = -1;
    int  m_gap = 0;
    int  m_ptr = NREQ - 1;
    int  m_stall = 0;
    bit  m_abort = 1'b0;
    bit  m_valid = 1'b0;

    // observations taken from the DUT
    int         grant_log[$];
    logic [7:0] acc_log[$];
    int         ack_cnt [NREQ];
    int         abort_cnt = 0;
    int         cyc = 0;
    int         last_ack_cyc = 0;
    int         abort_cyc = 0;
    logic [NREQ-1:0] prev_grant = '0;

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic push_msg(input int n, input int len);
        for (int i = 0; i < len; i++) q[n].push_back({(i == len - 1), 8'($urandom)});
    endtask

    task automatic clear_logs();
        grant_log.delete();
        acc_log.delete();
        for (int n = 0; n < NREQ; n++) ack_cnt[n] = 0;
        abort_cnt = 0;
    endtask

    task automatic cycle();
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] eack;
        logic            ew;
        logic            accepted;
        int              win;
        @(posedge i_clk);
        #1;
        cyc++;
        if (rnd_mode)
            for (int n = 0; n < NREQ; n++)
                if (q[n].size() == 0 && pause[n] == 0 && $urandom_range(19, 0) == 0)
                    push_msg(n, $urandom_range(4, 1));
        for (int n = 0; n < NREQ; n++) begin
            if (q[n].size() > 0 && pause[n] == 0) begin
                i_req[n] = 1'b1;
                i_data[8*n +: 8] = q[n][0][7:0];
                i_last[n] = q[n][0][8];
            end else begin
                i_req[n] = 1'b0;
                i_data[8*n +: 8] = 8'($urandom);
                i_last[n] = 1'($urandom);
            end
        end
        i_reset = rst_req;
        case (busy_mode)
            1:       i_uart_busy = ($urandom_range(9, 0) < 3);
            2:       i_uart_busy = busy_force;
            3:       i_uart_busy = (busy_cnt > 0);
            default: i_uart_busy = 1'b0;
        endcase
        @(negedge i_clk);
        eg = '0;
        ew = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ew = i_req[m_owner];
        end
        accepted = ew && !i_uart_busy;
        eack = accepted ? eg : '0;
        if (m_valid) begin
            check_val("grant", o_grant, eg);
            check_val("uart_wr", o_uart_wr, ew);
            check_val("ack", o_ack, eack);
            check_val("busy", o_busy, (m_owner >= 0) || (m_gap > 0));
            check_val("abort", o_abort, m_abort);
            if (ew) check_val("uart_data", o_uart_data, i_data[8*m_owner +: 8]);
        end
        if (o_grant != '0 && prev_grant == '0) grant_log.push_back(onehot_idx(o_grant));
        prev_grant = o_grant;
        if (o_uart_wr && !i_uart_busy) acc_log.push_back(o_uart_data);
        for (int n = 0; n < NREQ; n++) if (o_ack[n]) begin ack_cnt[n]++; last_ack_cyc = cyc; end
        if (o_abort) begin abort_cnt++; abort_cyc = cyc; end
        // model: rules applied at the coming clock edge
        if (i_reset) begin
            m_owner = -1; m_gap = 0; m_ptr = NREQ - 1; m_stall = 0; m_abort = 1'b0; m_valid = 1'b1;
        end else begin
            m_abort = 1'b0;
            if (m_owner >= 0) begin
                if (i_req[m_owner]) begin
                    m_stall = 0;
                    if (accepted && i_last[m_owner]) begin m_owner = -1; m_gap = GAP; end
                end else begin
                    m_stall++;
                    if (m_stall == STALL) begin m_abort = 1'b1; m_owner = -1; m_gap = GAP; m_stall = 0; end
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (i_req != '0) begin
                win = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (win < 0 && i_req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
                m_owner = win; m_ptr = win; m_stall = 0;
            end
        end
        // requesters and UART emulation
        if (i_reset) begin
            for (int n = 0; n < NREQ; n++) begin q[n].delete(); pause[n] = 0; pend_pause[n] = 0; end
            busy_cnt = 0;
        end else begin
            for (int n = 0; n < NREQ; n++) begin
                if (pause[n] > 0) pause[n]--;
                if (eack[n]) begin
                    void'(q[n].pop_front());
                    pause[n] = pend_pause[n];
                    pend_pause[n] = 0;
                    if (rnd_mode && $urandom_range(7, 0) == 0) pause[n] = $urandom_range(12, 1);
                end
            end
            if (accepted) busy_cnt = 10;
            else if (busy_cnt > 0) busy_cnt--;
        end
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        clear_logs();
    endtask

    task automatic wait_acks(input int n, input int cnt, input string tag);
        int t = 0;
        while (ack_cnt[n] < cnt && t < 400) begin cycle(); t++; end
        check_val(tag, t < 400, 1'b1);
    endtask

    initial begin
        int t;
        for (int n = 0; n < NREQ; n++) begin pause[n] = 0; pend_pause[n] = 0; ack_cnt[n] = 0; end
        repeat (3) cycle();
        rst_req = 1'b0;
        cycle();
        check_val("rst_busy", o_busy, 1'b0);
        check_val("rst_grant", o_grant, 4'b0000);
        check_val("rst_wr", o_uart_wr, 1'b0);
        check_val("rst_ack", o_ack, 4'b0000);
        check_val("rst_abort", o_abort, 1'b0);

        // "Hi\n" from requester 2, UART busy 10 cycles per byte
        clear_logs();
        busy_mode = 3;
        q[2].push_back({1'b0, 8'h48});
        q[2].push_back({1'b0, 8'h69});
        q[2].push_back({1'b1, 8'h0A});
        wait_acks(2, 3, "hi_timeout");
        t = 0;
        do begin cycle(); t++; end while (o_busy && t < 50);
        check_val("hi_idle_after", t, GAP + 1);
        check_val("hi_nbytes", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            check_val("hi_b0", acc_log[0], 8'h48);
            check_val("hi_b1", acc_log[1], 8'h69);
            check_val("hi_b2", acc_log[2], 8'h0A);
        end
        check_val("hi_grants", grant_log.size(), 1);
        if (grant_log.size() > 0) check_val("hi_owner", grant_log[0], 2);

        // round robin with all four requesting
        busy_mode = 0;
        do_reset();
        push_msg(0, 2); push_msg(0, 2);
        push_msg(1, 2); push_msg(2, 2); push_msg(3, 2);
        t = 0;
        while (grant_log.size() < 5 && t < 400) begin cycle(); t++; end
        check_val("rr_timeout", t < 400, 1'b1);
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size()) check_val($sformatf("rr_order%0d", i), grant_log[i], i % NREQ);
        wait_acks(0, 4, "rr_drain");

        // stall abort: owner 1 sends one byte then drops its request
        do_reset();
        q[1].push_back({1'b0, 8'hA1});
        q[1].push_back({1'b1, 8'hA2});
        pend_pause[1] = 20;
        q[2].push_back({1'b1, 8'hB1});
        t = 0;
        while (abort_cnt == 0 && t < 100) begin cycle(); t++; end
        check_val("stall_timeout", t < 100, 1'b1);
        check_val("stall_abort_delay", abort_cyc - last_ack_cyc, STALL + 1);
        check_val("stall_grant_clear", o_grant, 4'b0000);
        t = 0;
        while (grant_log.size() < 2 && t < 100) begin cycle(); t++; end
        check_val("stall_next_timeout", t < 100, 1'b1);
        if (grant_log.size() >= 2) check_val("stall_next_owner", grant_log[1], 2);
        check_val("stall_abort_cnt", abort_cnt, 1);
        repeat (40) cycle();

        // UART backpressure on owner 0
        do_reset();
        busy_mode = 2;
        busy_force = 1'b1;
        q[0].push_back({1'b1, 8'hC3});
        repeat (52) cycle();
        check_val("bp_no_ack", ack_cnt[0], 0);
        check_val("bp_no_abort", abort_cnt, 0);
        busy_force = 1'b0;
        cycle();
        check_val("bp_ack", ack_cnt[0], 1);
        if (acc_log.size() > 0) check_val("bp_byte", acc_log[0], 8'hC3);
        busy_mode = 0;
        repeat (GAP + 2) cycle();

        // reset in the middle of a 5-byte message
        do_reset();
        push_msg(0, 5);
        wait_acks(0, 1, "mid_timeout");
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        cycle();
        check_val("mid_grant", o_grant, 4'b0000);
        check_val("mid_wr", o_uart_wr, 1'b0);
        check_val("mid_ack", o_ack, 4'b0000);
        clear_logs();
        push_msg(0, 1);
        push_msg(3, 1);
        t = 0;
        while (grant_log.size() < 1 && t < 50) begin cycle(); t++; end
        check_val("mid_regrant_timeout", t < 50, 1'b1);
        if (grant_log.size() > 0) check_val("mid_regrant_owner", grant_log[0], 0);

        // randomized traffic with random backpressure and stalls
        do_reset();
        rnd_mode = 1'b1;
        busy_mode = 1;
        repeat (3000) cycle();
        rnd_mode = 1'b0;
        busy_mode = 0;
        repeat (200) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
